// File: rtl/multi_timer_if.sv
// multi_timer register bus: word-addressed reads/writes
// plus the per-channel and combined interrupt outputs.
interface multi_timer_if #(
  parameter int NUM_CH = 4,
  parameter int CH_AW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
  logic [CH_AW+1:0]  addr;
  logic              we;
  logic [31:0]       wd;
  logic [31:0]       rd;
  logic [NUM_CH-1:0] irq_vec;
  logic              irq;

  modport master (
    output addr, we, wd,
    input  rd, irq_vec, irq
  );

  modport slave (
    input  addr, we, wd,
    output rd, irq_vec, irq
  );
endinterface

// File: rtl/multi_timer.sv
// multi_timer: NUM_CH prescaled down-counters with one-shot or
// periodic reload, sticky W1C pending flags and a masked IRQ.
module multi_timer #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 32,
  parameter int CH_AW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input logic         clk,
  input logic         rst_n,
  multi_timer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    EXP  = 2'd3
  } state_t;

  state_t            state  [NUM_CH];
  logic [7:0]        psc    [NUM_CH];
  logic [7:0]        pre    [NUM_CH];
  logic [WIDTH-1:0]  preset [NUM_CH];
  logic [WIDTH-1:0]  count  [NUM_CH];
  logic [NUM_CH-1:0] en;
  logic [NUM_CH-1:0] mode;
  logic [NUM_CH-1:0] im;
  logic [NUM_CH-1:0] pend;

  logic [CH_AW-1:0]  ch;
  logic [1:0]        rsel;
  logic              ch_ok;
  logic [NUM_CH-1:0] sel;
  logic [NUM_CH-1:0] tick;

  assign ch    = bus.addr[CH_AW+1:2];
  assign rsel  = bus.addr[1:0];
  assign ch_ok = {1'b0, ch} < (CH_AW+1)'(NUM_CH);

  // per-channel write select and prescaler tick
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      sel[c]  = bus.we && ch_ok && (ch == CH_AW'(c));
      tick[c] = (pre[c] == psc[c]);
    end
  end

  // channel FSMs, then register writes (a write overrides FSM updates)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en   <= '0;
      mode <= '0;
      im   <= '0;
      pend <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        state[c]  <= IDLE;
        psc[c]    <= '0;
        pre[c]    <= '0;
        preset[c] <= '0;
        count[c]  <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (sel[c] && rsel == 2'd3 && bus.wd[0])
          pend[c] <= 1'b0;
        unique case (state[c])
          IDLE: begin
            if (en[c])
              state[c] <= LOAD;
          end
          LOAD: begin
            count[c] <= preset[c];
            pre[c]   <= '0;
            state[c] <= CNT;
          end
          CNT: begin
            if (!en[c]) begin
              state[c] <= IDLE;
            end else if (tick[c]) begin
              pre[c] <= '0;
              if (count[c] <= WIDTH'(1)) begin
                count[c] <= '0;
                pend[c]  <= 1'b1;
                state[c] <= EXP;
              end else begin
                count[c] <= count[c] - WIDTH'(1);
              end
            end else begin
              pre[c] <= pre[c] + 8'd1;
            end
          end
          EXP: begin
            if (!mode[c])
              en[c] <= 1'b0;
            state[c] <= (mode[c] && en[c]) ? LOAD : IDLE;
          end
          default: state[c] <= IDLE;
        endcase
        if (sel[c] && rsel == 2'd0) begin
          en[c]   <= bus.wd[0];
          mode[c] <= bus.wd[1];
          im[c]   <= bus.wd[3];
          psc[c]  <= bus.wd[15:8];
        end
        if (sel[c] && rsel == 2'd1)
          preset[c] <= bus.wd[WIDTH-1:0];
      end
    end
  end

  // read mux, zero for absent channels
  always_comb begin
    bus.rd = '0;
    if (ch_ok) begin
      unique case (rsel)
        2'd0: bus.rd = {16'b0, psc[ch], 4'b0,
                        im[ch], 1'b0, mode[ch], en[ch]};
        2'd1: bus.rd[WIDTH-1:0] = preset[ch];
        2'd2: bus.rd[WIDTH-1:0] = count[ch];
        2'd3: bus.rd[0] = pend[ch];
      endcase
    end
  end

  assign bus.irq_vec = pend & im;
  assign bus.irq     = |(pend & im);

endmodule

// File: tb/tb_multi_timer.sv
// tb_multi_timer: directed scenarios plus random register traffic,
// every cycle checked against a run-time based channel model.
module tb_multi_timer;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_fail = 0;
  int   ncyc = 0;

  multi_timer_if #(.NUM_CH(4)) bus ();

  multi_timer #(.NUM_CH(4), .WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #10 clk = ~clk;

  // model: age -1 idle, -2 expired, 0 loading, k>=1 counting
  int     age     [4];
  bit     m_en    [4];
  bit     m_mode  [4];
  bit     m_im    [4];
  bit     m_pend  [4];
  int     m_psc   [4];
  longint m_pre   [4];
  longint m_n     [4];
  longint m_cnt   [4];
  int     psc_fix [4];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] ad(input int c, input int r);
    logic [1:0] cc;
    logic [1:0] rr;
    cc = c[1:0];
    rr = r[1:0];
    return {cc, rr};
  endfunction

  task automatic m_reset();
    for (int c = 0; c < 4; c++) begin
      age[c] = -1;
      m_en[c] = 0; m_mode[c] = 0; m_im[c] = 0; m_pend[c] = 0;
      m_psc[c] = 0; m_pre[c] = 0; m_n[c] = 0; m_cnt[c] = 0;
    end
  endtask

  function automatic logic [31:0] m_rd(input logic [3:0] a);
    int c;
    logic [31:0] v;
    c = int'(a[3:2]);
    v = '0;
    case (a[1:0])
      2'd0: v = (m_psc[c] << 8) | (m_im[c] << 3)
                | (m_mode[c] << 1) | m_en[c];
      2'd1: v = m_pre[c][31:0];
      2'd2: v = m_cnt[c][31:0];
      default: v = {31'b0, m_pend[c]};
    endcase
    return v;
  endfunction

  function automatic logic [31:0] m_irqv();
    logic [31:0] v;
    v = '0;
    for (int c = 0; c < 4; c++)
      v[c] = m_pend[c] & m_im[c];
    return v;
  endfunction

  // advance the model one clock using pre-write control state
  task automatic m_step(input bit w, input logic [3:0] a,
                        input logic [31:0] d);
    int c;
    bit hw, en_n, clr;
    longint per, tot, q;
    for (c = 0; c < 4; c++) begin
      hw = 0;
      en_n = m_en[c];
      if (age[c] == -1) begin
        if (m_en[c]) age[c] = 0;
      end else if (age[c] == 0) begin
        m_n[c] = m_pre[c];
        m_cnt[c] = m_pre[c];
        age[c] = 1;
      end else if (age[c] == -2) begin
        if (!m_mode[c]) begin
          en_n = 0;
          age[c] = -1;
        end else begin
          age[c] = m_en[c] ? 0 : -1;
        end
      end else if (!m_en[c]) begin
        age[c] = -1;
      end else begin
        per = m_psc[c] + 1;
        tot = ((m_n[c] == 0) ? 1 : m_n[c]) * per;
        if (age[c] == tot) begin
          m_cnt[c] = 0;
          hw = 1;
          age[c] = -2;
        end else begin
          q = age[c] / per;
          m_cnt[c] = (m_n[c] > q) ? m_n[c] - q : 0;
          age[c]++;
        end
      end
      clr = w && a[3:2] == c[1:0] && a[1:0] == 2'd3 && d[0];
      m_pend[c] = hw | (m_pend[c] & !clr);
      m_en[c] = en_n;
      if (w && a[3:2] == c[1:0]) begin
        if (a[1:0] == 2'd0) begin
          m_en[c] = d[0];
          m_mode[c] = d[1];
          m_im[c] = d[3];
          m_psc[c] = int'(d[15:8]);
        end else if (a[1:0] == 2'd1) begin
          m_pre[c] = longint'(d);
        end
      end
    end
  endtask

  task automatic step(input bit w, input logic [3:0] a,
                      input logic [31:0] d);
    bus.we = w;
    bus.addr = a;
    bus.wd = d;
    #1;
    check("rd", bus.rd, m_rd(a));
    check("irq_vec", 32'(bus.irq_vec), m_irqv());
    check("irq", 32'(bus.irq), (m_irqv() != 0) ? 1 : 0);
    @(posedge clk);
    m_step(w, a, d);
    ncyc++;
    @(negedge clk);
  endtask

  task automatic peek(input logic [3:0] a, output logic [31:0] v);
    bus.we = 0;
    bus.addr = a;
    #1;
    v = bus.rd;
  endtask

  initial begin
    logic [31:0] v;
    int t, nr, k;
    int rr [4];
    bit prev, clr_next, pre_next;
    rst_n = 0;
    bus.we = 0;
    bus.addr = '0;
    bus.wd = '0;
    m_reset();
    repeat (3) @(negedge clk);
    rst_n = 1;
    for (int a = 0; a < 16; a++) begin
      bus.addr = 4'(a);
      #1;
      check("reset_rd", bus.rd, 0);
    end
    check("reset_irq", 32'(bus.irq), 0);

    // one-shot, channel 0
    step(1, ad(0, 1), 5);
    step(1, ad(0, 0), 32'h9);
    t = 0;
    for (k = 1; k <= 20; k++) begin
      step(0, ad(0, 3), 0);
      peek(ad(0, 3), v);
      if (v[0] && t == 0) t = k;
    end
    check("oneshot_lat", t, 7);
    check("oneshot_irq", 32'(bus.irq), 1);
    peek(ad(0, 0), v);
    check("oneshot_ctrl", v, 32'h8);
    peek(ad(0, 2), v);
    check("oneshot_cnt", v, 0);
    step(1, ad(0, 3), 1);

    // periodic with prescaler, masked, channel 1
    step(1, ad(1, 1), 3);
    step(1, ad(1, 0), 32'h203);
    rr = '{-1000, -1000, -1000, -1000};
    nr = 0; prev = 0; clr_next = 0;
    for (k = 0; k < 120 && nr < 2; k++) begin
      if (clr_next) begin
        step(1, ad(1, 3), 1);
        clr_next = 0;
      end else begin
        step(0, ad(1, 3), 0);
      end
      peek(ad(1, 3), v);
      if (v[0]) begin
        check("masked_irq", 32'(bus.irq), 0);
        if (!prev) begin
          rr[nr] = ncyc;
          nr++;
          clr_next = 1;
        end
      end
      prev = v[0];
    end
    check("psc_period", rr[1] - rr[0], 11);
    step(1, ad(1, 3), 1);
    for (k = 0; k < 40 && ncyc < rr[1] + 10; k++)
      step(0, ad(1, 3), 0);
    step(1, ad(1, 3), 1);
    peek(ad(1, 3), v);
    check("w1c_race", v, 1);
    step(1, ad(1, 0), 32'h20B);
    check("irq_on", 32'(bus.irq), 1);
    step(1, ad(1, 3), 1);
    check("irq_drop", 32'(bus.irq), 0);
    step(1, ad(1, 0), 0);
    repeat (3) step(0, ad(1, 2), 0);
    step(1, ad(1, 3), 1);

    // independence: channel 0 periodic, channel 3 hammered
    step(1, ad(0, 1), 4);
    step(1, ad(0, 0), 32'hB);
    rr = '{-1000, -1000, -1000, -1000};
    nr = 0; prev = 0; clr_next = 0; pre_next = 0;
    for (k = 0; k < 200 && nr < 4; k++) begin
      if (clr_next) begin
        step(1, ad(0, 3), 1);
        clr_next = 0;
      end else if (pre_next) begin
        step(1, ad(0, 1), 8);
        pre_next = 0;
      end else if (k % 2 == 0) begin
        step(1, ad(3, 1), $urandom);
      end else begin
        step(1, ad(3, 0), $urandom & 32'hFF0A);
      end
      if (bus.irq_vec[0] && !prev) begin
        rr[nr] = ncyc;
        nr++;
        clr_next = 1;
        if (nr == 2) pre_next = 1;
      end
      prev = bus.irq_vec[0];
    end
    check("indep_p1", rr[1] - rr[0], 6);
    check("indep_p2", rr[2] - rr[1], 6);
    check("indep_p3", rr[3] - rr[2], 10);
    step(1, ad(0, 0), 0);
    step(1, ad(3, 0), 0);
    repeat (3) step(0, ad(0, 2), 0);
    step(1, ad(0, 3), 1);

    // disable mid-count and restart, channel 2
    step(1, ad(2, 1), 40);
    step(1, ad(2, 0), 32'h1);
    for (k = 0; k < 60; k++) begin
      step(0, ad(2, 2), 0);
      peek(ad(2, 2), v);
      if (v == 21) break;
    end
    step(1, ad(2, 0), 0);
    repeat (10) step(0, ad(2, 2), 0);
    peek(ad(2, 2), v);
    check("hold_cnt", v, 20);
    peek(ad(2, 3), v);
    check("hold_pend", v, 0);
    step(1, ad(2, 0), 32'h1);
    peek(ad(2, 2), v);
    check("restart_w0", v, 20);
    step(0, ad(2, 2), 0);
    peek(ad(2, 2), v);
    check("restart_w1", v, 20);
    step(0, ad(2, 2), 0);
    peek(ad(2, 2), v);
    check("reload", v, 40);
    step(1, ad(2, 0), 0);
    repeat (3) step(0, ad(2, 2), 0);

    // asynchronous reset mid-count
    step(1, ad(2, 1), 50);
    step(1, ad(2, 0), 32'hB);
    repeat (10) step(0, ad(2, 2), 0);
    #1;
    rst_n = 0;
    m_reset();
    for (int a = 0; a < 16; a++) begin
      bus.addr = 4'(a);
      #1;
      check("async_rd", bus.rd, 0);
    end
    check("async_irq", 32'(bus.irq), 0);
    check("async_vec", 32'(bus.irq_vec), 0);
    @(negedge clk);
    rst_n = 1;
    repeat (100) step(0, ad(2, 2), 0);
    peek(ad(2, 2), v);
    check("post_rst_cnt", v, 0);
    check("post_rst_irq", 32'(bus.irq), 0);

    // random traffic, prescalers fixed per channel
    for (int c = 0; c < 4; c++)
      psc_fix[c] = $urandom_range(0, 2);
    for (k = 0; k < 1500; k++) begin
      int c, r, op;
      logic [31:0] d;
      c = $urandom_range(0, 3);
      r = $urandom_range(0, 3);
      op = $urandom_range(0, 9);
      if (op < 4) begin
        step(0, ad(c, r), $urandom);
      end else begin
        case (r)
          0: d = (psc_fix[c] << 8) | ($urandom & 32'hFFFF_00FF);
          1: d = $urandom_range(0, 10);
          default: d = $urandom;
        endcase
        step(1, ad(c, r), d);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_timer.md
# multi_timer

Parametrised multi-channel programmable timer for the MIPS CPU's memory-mapped peripheral bus. It provides NUM_CH independent down-counters, each with prescaler, one-shot or periodic auto-reload mode, a sticky write-1-to-clear pending flag and an interrupt mask. Per-channel interrupts are ORed onto one IRQ line for the CP0 interrupt input. A register write to one channel never stalls any other channel.

## Interface
- NUM_CH, 4, number of channels (1..8)
- WIDTH, 32, counter/PRESET width in bits (8..32); reads zero-extend to 32
- CH_AW, $clog2(NUM_CH) (min 1), channel-select address bits
- CLK  in  1  clock, all state updates on rising edge
- RST_N  in  1  asynchronous, active-low reset
- ADDR  in  CH_AW+2  word address {channel, reg[1:0]}; reg 0 CTRL, 1 PRESET, 2 COUNT, 3 STATUS
- WE  in  1  write enable
- WD  in  32  write data
- RD  out  32  read data, combinational from ADDR
- IRQ_VEC  out  NUM_CH  per-channel interrupt, PEND & IM
- IRQ  out  1  OR of IRQ_VEC

## Operation
- CTRL: bit0 EN, bit1 MODE (0 one-shot, 1 periodic), bit3 IM, bits[15:8] PSC. Other bits write-ignored, read 0.
- PRESET: WIDTH-bit reload value, read/write.
- COUNT: read-only, current count. Writes are ignored.
- STATUS: bit0 PEND. Writing 1 clears it, writing 0 has no effect. Other bits read 0.
- Channel index >= NUM_CH: reads 0, writes ignored.
- Prescaler: 8-bit per-channel counter. A tick occurs when the counter equals PSC, and the counter then returns to 0. So there is one tick every PSC+1 cycles in CNT.
- Per-channel FSM, encoded in 2 bits:
  - IDLE: if EN, go to LOAD.
  - LOAD: COUNT<=PRESET, prescaler<=0, go to CNT.
  - CNT: if !EN, go to IDLE and COUNT holds. Otherwise, on a tick:
    - if COUNT<=1: COUNT<=0, PEND<=1, go to EXP;
    - else COUNT<=COUNT-1.
  - EXP: if MODE=0, EN<=0 and go to IDLE. If MODE=1 and EN, go to LOAD. If MODE=1 and !EN, go to IDLE.
- PRESET writes take effect only at the next LOAD. The running COUNT is unaffected.
- A CTRL write in the same cycle as EXP clearing EN: the written value wins.
- The FSM evaluates its transition using the pre-write CTRL in the write cycle.
- A STATUS W1C in the same cycle as a hardware PEND set: the set wins, so PEND=1.
- Writing EN=1 to a channel already in CNT does not reload it. To restart, write EN=0, then EN=1.

## Timing
- Reset: all CTRL/PRESET/COUNT/STATUS are 0, all FSMs are in IDLE, prescalers are 0, and IRQ_VEC and IRQ are 0. This takes effect immediately on the RST_N fall, independent of CLK.
- Register writes are visible on RD the cycle after the write edge.
- IRQ_VEC and IRQ are combinational from registered PEND/IM: no extra latency after PEND sets, and no glitch from ADDR/WD.
- Latency from the EN-write edge to the first decrement: IDLE (1 cycle) + LOAD (1 cycle). The first tick then comes PSC+1 cycles into CNT.
- One-shot, PSC=0, PRESET=N>=1: PEND sets N+2 cycles after the cycle following the EN write.
- Periodic, PSC=0: PEND sets every N+2 cycles (LOAD + N CNT + EXP).
- Periodic, general: period = (N)(PSC+1)+2 cycles.
- PRESET=0 or 1: expires on the first tick, COUNT reads 0.
- RST_N asserted mid-count: the channel returns to IDLE at once. After release, the channel stays idle until software re-enables it.

## Test plan
- Reset: drive RST_N=0 mid-count on channel 2 (PRESET=50) -> immediately all RD fields read 0 and IRQ=0; after release, COUNT stays 0 and no IRQ appears for 100 cycles.
- One-shot: channel 0, PRESET=5, PSC=0, CTRL=0x9 -> PEND and IRQ rise exactly 7 cycles after the cycle following the write; CTRL reads 0x8 afterwards; COUNT reads 0.
- Periodic with prescaler: channel 1, PRESET=3, PSC=2, CTRL=0x0203 -> PEND sets every 11 cycles; with IM=0, IRQ stays 0 while STATUS reads 1.
- W1C race: write STATUS=1 on channel 1 in the same cycle the hardware sets PEND -> PEND=1. A later write of STATUS=1 clears PEND and drops IRQ the next cycle.
- Independence: a periodic channel 0 (N=4) runs while continuous writes go to channel 3 PRESET/CTRL -> channel 0's period is exactly 6 cycles with no stall. Changing channel 0 PRESET to 8 mid-count gives period 10 only after the next LOAD.
- Disable/restart: write EN=0 in CNT with COUNT=20 -> COUNT holds at 20 and no PEND. Then write EN=1 -> COUNT reloads to PRESET via LOAD.
